octant_mem_rsp_router: RTL and testbench

- Memory-side counterpart of the octree/BFS address select path.
- Accepts read requests from two requesters (octree core, BFS engine), arbitrates them onto one synchronous-read memory port, and tracks each in-flight read by requester ID.
- Returns each memory read word only to the requester that issued it, with a one-cycle valid pulse.
- Sits between the octant core / BFS engine and the shared node BRAM.

---
 rtl/octant_mem_rsp_router_pkg.sv | 31 +++
 rtl/octant_mem_rsp_router_arb.sv | 41 ++++
 rtl/octant_mem_rsp_router.sv | 135 +++++++++++++
 tb/tb_octant_mem_rsp_router.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/octant_mem_rsp_router_pkg.sv
// Shared constants and types for the octree/BFS memory response router.
// ADDR_SIZE_DEF is also used by the address select path.
package octant_mem_rsp_router_pkg;

  localparam int ADDR_SIZE_DEF = 4;
  localparam int DATA_SIZE_DEF = 32;

  localparam logic ID_OCTREE = 1'b0;
  localparam logic ID_BFS    = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  // Returns 1 when BFS should win this cycle, given who is requesting.
  function automatic logic arb_pick_bfs(input logic req_octree,
                                        input logic req_bfs,
                                        input logic ptr_favours_bfs,
                                        input logic bfs_priority);
    logic pick;
    pick = 1'b0;
    if (req_bfs && !req_octree) begin
      pick = 1'b1;
    end else if (req_bfs && req_octree) begin
      pick = bfs_priority | ptr_favours_bfs;
    end
    return pick;
  endfunction

endpackage

// File: rtl/octant_mem_rsp_router_arb.sv
// Two-input arbiter between the octree core and the BFS engine.
// Round-robin pointer flips after every grant; BFS_PRIORITY makes BFS win ties.
module octant_rr_arb2
  import octant_mem_rsp_router_pkg::*;
#(
  parameter bit BFS_PRIORITY = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req_octree,
  input  logic i_req_bfs,
  output logic o_gnt_octree,
  output logic o_gnt_bfs
);

  logic ptr_q;
  logic ptr_d;
  logic pick_bfs;

  // Grants are gated by reset so nothing is accepted while held in reset.
  always_comb begin
    pick_bfs     = arb_pick_bfs(i_req_octree, i_req_bfs, ptr_q, BFS_PRIORITY);
    o_gnt_bfs    = i_rst_n & i_req_bfs & pick_bfs;
    o_gnt_octree = i_rst_n & i_req_octree & ~pick_bfs;
    ptr_d        = ptr_q;
    if (o_gnt_octree) begin
      ptr_d = ID_BFS;
    end else if (o_gnt_bfs) begin
      ptr_d = ID_OCTREE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= ID_OCTREE;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/octant_mem_rsp_router.sv
// Arbitrates octree/BFS reads onto one synchronous-read memory port and routes
// each returned word back to the requester that issued it.
module octant_mem_rsp_router
  import octant_mem_rsp_router_pkg::*;
#(
  parameter int ADDR_SIZE    = ADDR_SIZE_DEF,
  parameter int DATA_SIZE    = DATA_SIZE_DEF,
  parameter int MEM_LATENCY  = 1,
  parameter bit BFS_PRIORITY = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req_octree,
  input  logic [ADDR_SIZE-1:0] i_addr_octree,
  output logic                 o_gnt_octree,
  input  logic                 i_req_bfs,
  input  logic [ADDR_SIZE-1:0] i_addr_bfs,
  output logic                 o_gnt_bfs,
  output logic                 o_mem_en,
  output logic [ADDR_SIZE-1:0] o_mem_addr,
  input  logic [DATA_SIZE-1:0] i_mem_rdata,
  output logic [DATA_SIZE-1:0] o_rdata_octree,
  output logic                 o_rvalid_octree,
  output logic [DATA_SIZE-1:0] o_rdata_bfs,
  output logic                 o_rvalid_bfs
);

  logic gnt_octree;
  logic gnt_bfs;

  octant_rr_arb2 #(
    .BFS_PRIORITY (BFS_PRIORITY)
  ) u_arb (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_octree (i_req_octree),
    .i_req_bfs    (i_req_bfs),
    .o_gnt_octree (gnt_octree),
    .o_gnt_bfs    (gnt_bfs)
  );

  assign o_gnt_octree = gnt_octree;
  assign o_gnt_bfs    = gnt_bfs;

  logic                 mem_en_q;
  logic                 mem_en_d;
  logic [ADDR_SIZE-1:0] mem_addr_q;
  logic [ADDR_SIZE-1:0] mem_addr_d;
  logic                 issue_id_q;
  logic                 issue_id_d;

  always_comb begin
    mem_en_d   = gnt_octree | gnt_bfs;
    mem_addr_d = mem_addr_q;
    issue_id_d = issue_id_q;
    if (gnt_bfs) begin
      mem_addr_d = i_addr_bfs;
      issue_id_d = ID_BFS;
    end else if (gnt_octree) begin
      mem_addr_d = i_addr_octree;
      issue_id_d = ID_OCTREE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      issue_id_q <= ID_OCTREE;
    end else begin
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      issue_id_q <= issue_id_d;
    end
  end

  assign o_mem_en   = mem_en_q;
  assign o_mem_addr = mem_addr_q;

  // One tag per memory pipeline stage; the head lines up with i_mem_rdata.
  tag_t tag_q [MEM_LATENCY];
  tag_t head;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= '{valid: mem_en_q, id: issue_id_q};
      for (int i = 1; i < MEM_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign head = tag_q[MEM_LATENCY-1];

  logic                 rvalid_octree_q;
  logic                 rvalid_octree_d;
  logic                 rvalid_bfs_q;
  logic                 rvalid_bfs_d;
  logic [DATA_SIZE-1:0] rdata_octree_q;
  logic [DATA_SIZE-1:0] rdata_octree_d;
  logic [DATA_SIZE-1:0] rdata_bfs_q;
  logic [DATA_SIZE-1:0] rdata_bfs_d;

  // Only the tagged requester's data register captures; the other holds.
  always_comb begin
    rvalid_octree_d = head.valid & (head.id == ID_OCTREE);
    rvalid_bfs_d    = head.valid & (head.id == ID_BFS);
    rdata_octree_d  = rvalid_octree_d ? i_mem_rdata : rdata_octree_q;
    rdata_bfs_d     = rvalid_bfs_d    ? i_mem_rdata : rdata_bfs_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rvalid_octree_q <= 1'b0;
      rvalid_bfs_q    <= 1'b0;
      rdata_octree_q  <= '0;
      rdata_bfs_q     <= '0;
    end else begin
      rvalid_octree_q <= rvalid_octree_d;
      rvalid_bfs_q    <= rvalid_bfs_d;
      rdata_octree_q  <= rdata_octree_d;
      rdata_bfs_q     <= rdata_bfs_d;
    end
  end

  assign o_rvalid_octree = rvalid_octree_q;
  assign o_rvalid_bfs    = rvalid_bfs_q;
  assign o_rdata_octree  = rdata_octree_q;
  assign o_rdata_bfs     = rdata_bfs_q;

endmodule

// File: tb/tb_octant_mem_rsp_router.sv
// Bench for octant_mem_rsp_router: three instances (RR/lat1, BFS-priority/lat1,
// RR/lat3) share the request inputs and are checked against a queue-based model.
module tb_octant_mem_rsp_router;

  localparam int NDUT = 3;
  localparam int LAT [NDUT] = '{1, 1, 3};
  localparam bit PRI [NDUT] = '{1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req_o, req_b;
  logic [3:0] addr_o, addr_b;

  logic [NDUT-1:0]        gnt_o, gnt_b, en, rvo, rvb;
  logic [NDUT-1:0][3:0]   maddr;
  logic [NDUT-1:0][31:0]  rdo, rdb, mrd;
  logic [31:0]            mpipe [NDUT][4];

  octant_mem_rsp_router #(.ADDR_SIZE(4), .DATA_SIZE(32), .MEM_LATENCY(1), .BFS_PRIORITY(1'b0)) dut_rr (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_octree(req_o), .i_addr_octree(addr_o), .o_gnt_octree(gnt_o[0]),
    .i_req_bfs(req_b), .i_addr_bfs(addr_b), .o_gnt_bfs(gnt_b[0]),
    .o_mem_en(en[0]), .o_mem_addr(maddr[0]), .i_mem_rdata(mrd[0]),
    .o_rdata_octree(rdo[0]), .o_rvalid_octree(rvo[0]),
    .o_rdata_bfs(rdb[0]), .o_rvalid_bfs(rvb[0]));

  octant_mem_rsp_router #(.ADDR_SIZE(4), .DATA_SIZE(32), .MEM_LATENCY(1), .BFS_PRIORITY(1'b1)) dut_pr (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_octree(req_o), .i_addr_octree(addr_o), .o_gnt_octree(gnt_o[1]),
    .i_req_bfs(req_b), .i_addr_bfs(addr_b), .o_gnt_bfs(gnt_b[1]),
    .o_mem_en(en[1]), .o_mem_addr(maddr[1]), .i_mem_rdata(mrd[1]),
    .o_rdata_octree(rdo[1]), .o_rvalid_octree(rvo[1]),
    .o_rdata_bfs(rdb[1]), .o_rvalid_bfs(rvb[1]));

  octant_mem_rsp_router #(.ADDR_SIZE(4), .DATA_SIZE(32), .MEM_LATENCY(3), .BFS_PRIORITY(1'b0)) dut_l3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_octree(req_o), .i_addr_octree(addr_o), .o_gnt_octree(gnt_o[2]),
    .i_req_bfs(req_b), .i_addr_bfs(addr_b), .o_gnt_bfs(gnt_b[2]),
    .o_mem_en(en[2]), .o_mem_addr(maddr[2]), .i_mem_rdata(mrd[2]),
    .o_rdata_octree(rdo[2]), .o_rvalid_octree(rvo[2]),
    .o_rdata_bfs(rdb[2]), .o_rvalid_bfs(rvb[2]));

  function automatic logic [31:0] memdata(input logic [3:0] a);
    return 32'hA5A5_0000 | {28'h0, a};
  endfunction

  // Memory: word appears LAT cycles after the enable; garbage otherwise.
  always @(posedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      mpipe[k][0] <= en[k] ? memdata(maddr[k]) : $urandom;
      for (int j = 1; j < 4; j++) mpipe[k][j] <= mpipe[k][j-1];
    end
  end
  assign mrd[0] = mpipe[0][0];
  assign mrd[1] = mpipe[1][0];
  assign mrd[2] = mpipe[2][2];

  // Reference model state
  typedef struct {
    int          k;
    int          due;
    bit          is_bfs;
    logic [31:0] data;
  } rsp_t;
  rsp_t        sb [$];
  bit          m_fav_bfs [NDUT];
  bit          m_en [NDUT];
  logic [3:0]  m_addr [NDUT];
  logic [31:0] m_rdo [NDUT];
  logic [31:0] m_rdb [NDUT];

  int cyc = 0;
  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic void model_gnt(input int k, output bit go, output bit gb);
    go = 1'b0;
    gb = 1'b0;
    if (rst_n) begin
      if (req_o && req_b) begin
        if (PRI[k] || m_fav_bfs[k]) gb = 1'b1;
        else go = 1'b1;
      end else if (req_o) go = 1'b1;
      else if (req_b) gb = 1'b1;
    end
  endfunction

  task automatic model_check();
    bit go, gb, eo, eb;
    int idx;
    if (!rst_n) begin
      sb.delete();
      for (int k = 0; k < NDUT; k++) begin
        m_fav_bfs[k] = 1'b0; m_en[k] = 1'b0; m_addr[k] = '0;
        m_rdo[k] = '0; m_rdb[k] = '0;
      end
    end
    for (int k = 0; k < NDUT; k++) begin
      model_gnt(k, go, gb);
      chk($sformatf("gnt_oct[%0d]", k), 32'(gnt_o[k]), 32'(go));
      chk($sformatf("gnt_bfs[%0d]", k), 32'(gnt_b[k]), 32'(gb));
      chk($sformatf("mem_en[%0d]", k), 32'(en[k]), 32'(m_en[k]));
      chk($sformatf("mem_addr[%0d]", k), 32'(maddr[k]), 32'(m_addr[k]));
      eo = 1'b0; eb = 1'b0; idx = -1;
      for (int i = 0; i < sb.size(); i++) begin
        if (sb[i].k == k) begin idx = i; break; end
      end
      if (idx >= 0 && sb[idx].due == cyc) begin
        if (sb[idx].is_bfs) begin eb = 1'b1; m_rdb[k] = sb[idx].data; end
        else begin eo = 1'b1; m_rdo[k] = sb[idx].data; end
        sb.delete(idx);
      end
      chk($sformatf("rvalid_oct[%0d]", k), 32'(rvo[k]), 32'(eo));
      chk($sformatf("rvalid_bfs[%0d]", k), 32'(rvb[k]), 32'(eb));
      chk($sformatf("rdata_oct[%0d]", k), rdo[k], m_rdo[k]);
      chk($sformatf("rdata_bfs[%0d]", k), rdb[k], m_rdb[k]);
    end
  endtask

  task automatic model_update();
    bit go, gb;
    rsp_t r;
    for (int k = 0; k < NDUT; k++) begin
      model_gnt(k, go, gb);
      if (go || gb) begin
        m_en[k]      = 1'b1;
        m_addr[k]    = gb ? addr_b : addr_o;
        m_fav_bfs[k] = go;
        r.k      = k;
        r.due    = cyc + LAT[k] + 2;
        r.is_bfs = gb;
        r.data   = memdata(m_addr[k]);
        sb.push_back(r);
      end else begin
        m_en[k] = 1'b0;
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_check();
  endtask

  task automatic to_next();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    req_o = 1'b0;
    req_b = 1'b0;
    repeat (n) begin at_neg(); to_next(); end
  endtask

  typedef struct {
    bit ro; logic [3:0] ao; bit rb; logic [3:0] ab;
    bit rr_go; bit rr_gb; bit pr_go; bit pr_gb;
  } vec_t;
  vec_t tbl [13];

  logic [3:0] seq [6];

  initial begin
    // Arbitration table from reset: both instances start favouring octree.
    tbl[0]  = '{1, 4'h1, 1, 4'h2, 1, 0, 0, 1};
    tbl[1]  = '{1, 4'h1, 1, 4'h2, 0, 1, 0, 1};
    tbl[2]  = '{1, 4'h1, 1, 4'h2, 1, 0, 0, 1};
    tbl[3]  = '{1, 4'h1, 1, 4'h2, 0, 1, 0, 1};
    tbl[4]  = '{1, 4'hF, 0, 4'h0, 1, 0, 1, 0};
    tbl[5]  = '{0, 4'h0, 1, 4'hF, 0, 1, 0, 1};
    tbl[6]  = '{0, 4'h3, 0, 4'h4, 0, 0, 0, 0};
    tbl[7]  = '{1, 4'h5, 1, 4'h6, 1, 0, 0, 1};
    tbl[8]  = '{0, 4'h5, 0, 4'h6, 0, 0, 0, 0};
    tbl[9]  = '{1, 4'h7, 1, 4'h8, 0, 1, 0, 1};
    tbl[10] = '{1, 4'h9, 0, 4'hA, 1, 0, 1, 0};
    tbl[11] = '{1, 4'hB, 0, 4'hC, 1, 0, 1, 0};
    tbl[12] = '{1, 4'hD, 1, 4'hE, 0, 1, 0, 1};
    seq = '{4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4};

    req_o = 1'b1; req_b = 1'b1; addr_o = 4'h5; addr_b = 4'h6;
    #1;
    repeat (3) begin
      at_neg();
      chk("rst_gnt_oct", 32'(gnt_o[0]), 32'd0);
      chk("rst_gnt_bfs", 32'(gnt_b[0]), 32'd0);
      chk("rst_mem_en", 32'(en[0]), 32'd0);
      chk("rst_rdata_oct", rdo[0], 32'd0);
      to_next();
    end
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      req_o = tbl[i].ro; addr_o = tbl[i].ao; req_b = tbl[i].rb; addr_b = tbl[i].ab;
      at_neg();
      chk($sformatf("tbl%0d_rr_go", i), 32'(gnt_o[0]), 32'(tbl[i].rr_go));
      chk($sformatf("tbl%0d_rr_gb", i), 32'(gnt_b[0]), 32'(tbl[i].rr_gb));
      chk($sformatf("tbl%0d_l3_go", i), 32'(gnt_o[2]), 32'(tbl[i].rr_go));
      chk($sformatf("tbl%0d_pr_go", i), 32'(gnt_o[1]), 32'(tbl[i].pr_go));
      chk($sformatf("tbl%0d_pr_gb", i), 32'(gnt_b[1]), 32'(tbl[i].pr_gb));
      to_next();
    end
    idle(8);

    // Single octree read of address 3: rvalid at grant+3 (lat1), grant+5 (lat3).
    for (int t = 0; t < 7; t++) begin
      req_o = (t == 0); addr_o = 4'h3; req_b = 1'b0;
      at_neg();
      if (t == 0) chk("single_gnt", 32'(gnt_o[0]), 32'd1);
      if (t == 1) begin
        chk("single_en", 32'(en[0]), 32'd1);
        chk("single_addr", 32'(maddr[0]), 32'h3);
      end
      chk("single_rv_lat1", 32'(rvo[0]), 32'(t == 3));
      chk("single_rvb_lat1", 32'(rvb[0]), 32'd0);
      chk("single_rv_lat3", 32'(rvo[2]), 32'(t == 5));
      if (t == 3) chk("single_data_lat1", rdo[0], 32'hA5A5_0003);
      if (t == 5) chk("single_data_lat3", rdo[2], 32'hA5A5_0003);
      to_next();
    end
    idle(4);

    // Six alternating back-to-back reads with address wrap, latency-3 instance.
    for (int t = 0; t < 14; t++) begin
      if (t < 6) begin
        req_o = (t % 2 == 0); req_b = (t % 2 == 1);
        addr_o = seq[t]; addr_b = seq[t];
      end else begin
        req_o = 1'b0; req_b = 1'b0;
      end
      at_neg();
      if (t >= 5 && t <= 10) begin
        chk($sformatf("b2b_rvo%0d", t - 5), 32'(rvo[2]), 32'((t - 5) % 2 == 0));
        chk($sformatf("b2b_rvb%0d", t - 5), 32'(rvb[2]), 32'((t - 5) % 2 == 1));
        if ((t - 5) % 2 == 0) chk($sformatf("b2b_do%0d", t - 5), rdo[2], memdata(seq[t - 5]));
        else chk($sformatf("b2b_db%0d", t - 5), rdb[2], memdata(seq[t - 5]));
      end
      to_next();
    end
    idle(4);

    // Reset one cycle after issue, released two cycles later; then a BFS read.
    for (int t = 0; t < 13; t++) begin
      rst_n = !(t == 2 || t == 3);
      req_o = (t == 0); addr_o = 4'h7;
      req_b = (t == 8); addr_b = 4'h9;
      at_neg();
      if (t < 8) begin
        chk("flush_rvo_lat1", 32'(rvo[0]), 32'd0);
        chk("flush_rvo_lat3", 32'(rvo[2]), 32'd0);
      end
      if (t == 11) begin
        chk("post_rst_rvb", 32'(rvb[0]), 32'd1);
        chk("post_rst_data", rdb[0], 32'hA5A5_0009);
      end
      to_next();
    end
    rst_n = 1'b1;
    idle(4);

    // Random traffic with occasional reset pulses, checked by the model.
    for (int t = 0; t < 400; t++) begin
      rst_n  = ($urandom_range(0, 63) != 0);
      req_o  = 1'($urandom_range(0, 1));
      req_b  = 1'($urandom_range(0, 1));
      addr_o = 4'($urandom);
      addr_b = 4'($urandom);
      at_neg();
      to_next();
    end
    rst_n = 1'b1;
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
